// File: rtl/instr_sequencer.sv
// Fetch/decode/memory/retire sequencer wrapped around the combinational instruction controller.
// Owns the instruction register, tolerates memory wait states and traps on timeouts/undefined ops.
module instr_sequencer #(
    parameter int unsigned TIMEOUT   = 15,
    parameter int unsigned INSTRET_W = 16
) (
    input  logic                 CLOCK_50,
    input  logic                 RESET_N,
    input  logic                 run,
    output logic                 imem_req,
    input  logic                 imem_ack,
    input  logic [31:0]          imem_rdata,
    output logic [31:0]          IR_out,
    input  logic                 cond_pass,
    input  logic                 Wen_ARd_dec,
    input  logic                 Wen_Dmem_dec,
    input  logic                 Wen_Flags_dec,
    output logic                 Wen_ARd,
    output logic                 Wen_Dmem,
    output logic                 Wen_Flags,
    output logic                 dmem_req,
    output logic                 dmem_we,
    input  logic                 dmem_ack,
    output logic                 PC_en,
    output logic                 PC_sel_branch,
    output logic [2:0]           state_out,
    output logic                 fault,
    output logic [1:0]           fault_code,
    output logic [INSTRET_W-1:0] instret
);

    localparam logic [2:0] StIdle   = 3'b000;
    localparam logic [2:0] StFetch  = 3'b001;
    localparam logic [2:0] StDecode = 3'b010;
    localparam logic [2:0] StMem    = 3'b011;
    localparam logic [2:0] StRetire = 3'b100;
    localparam logic [2:0] StFault  = 3'b111;

    localparam int unsigned       CntW    = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0]   CntLast = CntW'(TIMEOUT - 1);

    logic [2:0]           state_q, state_d;
    logic [31:0]          ir_q, ir_d;
    logic [CntW-1:0]      wait_cnt_q, wait_cnt_d;
    logic [INSTRET_W-1:0] instret_q, instret_d;
    logic [1:0]           fault_code_q, fault_code_d;

    logic [1:0] instr_class;
    logic       is_load;
    logic       in_retire;

    assign instr_class = ir_q[27:26];
    assign is_load     = ir_q[20];
    assign in_retire   = (state_q == StRetire);

    always_comb begin
        state_d      = state_q;
        ir_d         = ir_q;
        wait_cnt_d   = wait_cnt_q;
        instret_d    = instret_q;
        fault_code_d = fault_code_q;
        case (state_q)
            StIdle: begin
                if (run) begin
                    state_d    = StFetch;
                    wait_cnt_d = '0;
                end
            end
            StFetch: begin
                // An ack on the final allowed cycle takes priority over the timeout.
                if (imem_ack) begin
                    ir_d       = imem_rdata;
                    state_d    = StDecode;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == CntLast) begin
                    state_d      = StFault;
                    fault_code_d = 2'b01;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            StDecode: begin
                if (instr_class == 2'b11) begin
                    state_d      = StFault;
                    fault_code_d = 2'b11;
                end else if (instr_class == 2'b01 && cond_pass) begin
                    state_d    = StMem;
                    wait_cnt_d = '0;
                end else begin
                    state_d = StRetire;
                end
            end
            StMem: begin
                if (dmem_ack) begin
                    state_d = StRetire;
                end else if (wait_cnt_q == CntLast) begin
                    state_d      = StFault;
                    fault_code_d = 2'b10;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            StRetire: begin
                instret_d  = instret_q + 1'b1;
                wait_cnt_d = '0;
                state_d    = run ? StFetch : StIdle;
            end
            StFault: begin
                state_d = StFault;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= StIdle;
            ir_q         <= '0;
            wait_cnt_q   <= '0;
            instret_q    <= '0;
            fault_code_q <= 2'b00;
        end else begin
            state_q      <= state_d;
            ir_q         <= ir_d;
            wait_cnt_q   <= wait_cnt_d;
            instret_q    <= instret_d;
            fault_code_q <= fault_code_d;
        end
    end

    // Decoded enables are qualified so each architectural write fires once per instruction.
    assign imem_req      = (state_q == StFetch);
    assign dmem_req      = (state_q == StMem);
    assign dmem_we       = dmem_req & ~is_load;
    assign Wen_Dmem      = dmem_we & Wen_Dmem_dec;
    assign Wen_ARd       = in_retire & Wen_ARd_dec &
                           ((instr_class == 2'b00) | ((instr_class == 2'b01) & is_load));
    assign Wen_Flags     = in_retire & Wen_Flags_dec & (instr_class == 2'b00);
    assign PC_en         = in_retire;
    assign PC_sel_branch = in_retire & (instr_class == 2'b10) & cond_pass;

    assign state_out  = state_q;
    assign fault      = (state_q == StFault);
    assign fault_code = fault_code_q;
    assign IR_out     = ir_q;
    assign instret    = instret_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomized bench for instr_sequencer: an instruction-level model predicts every cycle's outputs.
module tb_instr_sequencer;

    localparam int unsigned TimeoutCyc = 4;
    localparam int unsigned InstretW   = 4;

    logic                CLOCK_50 = 1'b0;
    logic                RESET_N = 1'b0;
    logic                run = 1'b0;
    logic                imem_ack = 1'b0;
    logic [31:0]         imem_rdata = '0;
    logic                cond_pass = 1'b0;
    logic                Wen_ARd_dec = 1'b0;
    logic                Wen_Dmem_dec = 1'b0;
    logic                Wen_Flags_dec = 1'b0;
    logic                dmem_ack = 1'b0;
    logic                imem_req, dmem_req, dmem_we, Wen_ARd, Wen_Dmem, Wen_Flags;
    logic                PC_en, PC_sel_branch, fault;
    logic [31:0]         IR_out;
    logic [2:0]          state_out;
    logic [1:0]          fault_code;
    logic [InstretW-1:0] instret;

    instr_sequencer #(
        .TIMEOUT  (TimeoutCyc),
        .INSTRET_W(InstretW)
    ) dut (
        .CLOCK_50     (CLOCK_50),
        .RESET_N      (RESET_N),
        .run          (run),
        .imem_req     (imem_req),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .IR_out       (IR_out),
        .cond_pass    (cond_pass),
        .Wen_ARd_dec  (Wen_ARd_dec),
        .Wen_Dmem_dec (Wen_Dmem_dec),
        .Wen_Flags_dec(Wen_Flags_dec),
        .Wen_ARd      (Wen_ARd),
        .Wen_Dmem     (Wen_Dmem),
        .Wen_Flags    (Wen_Flags),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_ack     (dmem_ack),
        .PC_en        (PC_en),
        .PC_sel_branch(PC_sel_branch),
        .state_out    (state_out),
        .fault        (fault),
        .fault_code   (fault_code),
        .instret      (instret)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    // Expected outputs for the current cycle, strobes packed as
    // {imem_req, dmem_req, dmem_we, Wen_ARd, Wen_Dmem, Wen_Flags, PC_en, PC_sel_branch}.
    logic [2:0]  e_state;
    logic [7:0]  e_strb;
    logic [2:0]  e_flt;
    logic [31:0] e_ir;
    logic [31:0] e_instret;

    logic [31:0] m_ir;
    int          m_instret;
    bit          m_idle;
    bit          m_faulted;
    logic [1:0]  m_code;

    logic [7:0] strb;
    assign strb = {imem_req, dmem_req, dmem_we, Wen_ARd, Wen_Dmem, Wen_Flags, PC_en, PC_sel_branch};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge CLOCK_50) begin
        if (chk_en) begin
            chk("state", 32'(state_out), 32'(e_state));
            chk("strobes", 32'(strb), 32'(e_strb));
            chk("fault", 32'({fault, fault_code}), 32'(e_flt));
            chk("ir", IR_out, e_ir);
            chk("instret", 32'(instret), e_instret);
        end
    end

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic set_exp(input logic [2:0] st, input logic [7:0] sb);
        e_state   = st;
        e_strb    = sb;
        e_flt     = (st == 3'b111) ? {1'b1, m_code} : 3'b000;
        e_ir      = m_ir;
        e_instret = 32'(m_instret);
    endtask

    task automatic scramble();
        run           = 1'($urandom);
        imem_ack      = 1'($urandom);
        dmem_ack      = 1'($urandom);
        cond_pass     = 1'($urandom);
        Wen_ARd_dec   = 1'($urandom);
        Wen_Dmem_dec  = 1'($urandom);
        Wen_Flags_dec = 1'($urandom);
        imem_rdata    = $urandom;
    endtask

    task automatic do_reset();
        m_ir      = '0;
        m_instret = 0;
        m_idle    = 1'b1;
        m_faulted = 1'b0;
        m_code    = 2'b00;
        set_exp(3'b000, 8'h00);
        RESET_N = 1'b0;
        #1;
        chk("rst_state", 32'(state_out), 32'd0);
        chk("rst_strobes", 32'(strb), 32'd0);
        chk("rst_fault", 32'({fault, fault_code}), 32'd0);
        chk("rst_instret", 32'(instret), 32'd0);
        chk("rst_ir", IR_out, 32'd0);
        scramble();
        run = 1'b0;
        step();
        step();
        RESET_N = 1'b1;
    endtask

    task automatic do_fault(input logic [1:0] code);
        m_code    = code;
        m_faulted = 1'b1;
        for (int k = 0; k < 3; k++) begin
            scramble();
            set_exp(3'b111, 8'h00);
            step();
        end
    endtask

    // One instruction: iw/dw are wait cycles before the ack (>= TimeoutCyc means no ack),
    // rst_mem >= 0 pulses reset during that MEM cycle.
    task automatic do_instr(input logic [31:0] w, input int iw, input int dw, input bit cp,
                            input bit ard, input bit dm, input bit fl, input bit run_after,
                            input int rst_mem, output int ncyc);
        logic [1:0] cls;
        bit         ld;
        bit         wa, wf, ps;
        cls  = w[27:26];
        ld   = w[20];
        ncyc = 0;
        if (m_idle) begin
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                scramble();
                run = 1'b0;
                set_exp(3'b000, 8'h00);
                step();
            end
            scramble();
            run = 1'b1;
            set_exp(3'b000, 8'h00);
            step();
            m_idle = 1'b0;
        end
        for (int k = 0; k < 64; k++) begin
            scramble();
            imem_ack   = (k == iw);
            imem_rdata = (k == iw) ? w : $urandom;
            set_exp(3'b001, 8'b1000_0000);
            step();
            ncyc++;
            if (k == iw) break;
            if (k == int'(TimeoutCyc) - 1) begin
                do_fault(2'b01);
                return;
            end
        end
        m_ir = w;
        scramble();
        cond_pass = cp;
        set_exp(3'b010, 8'h00);
        step();
        ncyc++;
        if (cls == 2'b11) begin
            do_fault(2'b11);
            return;
        end
        if (cls == 2'b01 && cp) begin
            for (int k = 0; k < 64; k++) begin
                scramble();
                Wen_Dmem_dec = dm;
                dmem_ack     = (k == dw);
                if (k == rst_mem) begin
                    do_reset();
                    return;
                end
                set_exp(3'b011, {1'b0, 1'b1, ~ld, 1'b0, dm & ~ld, 3'b000});
                step();
                ncyc++;
                if (k == dw) break;
                if (k == int'(TimeoutCyc) - 1) begin
                    do_fault(2'b10);
                    return;
                end
            end
        end
        scramble();
        cond_pass     = cp;
        Wen_ARd_dec   = ard;
        Wen_Dmem_dec  = dm;
        Wen_Flags_dec = fl;
        run           = run_after;
        wa = ard && (cls == 2'b00 || (cls == 2'b01 && ld));
        wf = fl && (cls == 2'b00);
        ps = (cls == 2'b10) && cp;
        set_exp(3'b100, {3'b000, wa, 1'b0, wf, 1'b1, ps});
        step();
        ncyc++;
        m_instret = (m_instret + 1) % (1 << InstretW);
        if (!run_after) m_idle = 1'b1;
    endtask

    initial begin
        int nc;
        m_ir      = '0;
        m_instret = 0;
        m_idle    = 1'b1;
        m_faulted = 1'b0;
        m_code    = 2'b00;
        set_exp(3'b000, 8'h00);
        chk_en  = 1'b1;
        RESET_N = 1'b0;
        step();
        step();
        RESET_N = 1'b1;

        do_instr(32'hE0810312, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, -1, nc);
        chk("add_cycles", 32'(nc), 32'd3);
        chk("add_instret", 32'(instret), 32'd1);
        do_instr(32'h04110003, 0, 3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, -1, nc);
        chk("ldr_cycles", 32'(nc), 32'd7);
        chk("ldr_ir", IR_out, 32'h04110003);
        do_instr(32'h06010012, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, -1, nc);
        chk("str_cycles", 32'(nc), 32'd4);
        do_instr(32'h8A000008, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, -1, nc);
        chk("bhi_taken_cycles", 32'(nc), 32'd3);
        do_instr(32'h8A000008, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, nc);
        chk("bhi_instret", 32'(instret), 32'd5);

        do_instr(32'hE0810312, 3, 0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, -1, nc);
        chk("late_ack_cycles", 32'(nc), 32'd6);
        chk("late_ack_nofault", 32'(fault), 32'd0);
        do_instr(32'hE0810312, 99, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, -1, nc);
        chk("imem_to_cycles", 32'(nc), 32'd4);
        chk("imem_to_code", 32'({fault, fault_code}), 32'b101);
        do_reset();
        do_instr(32'h0C000000, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, -1, nc);
        chk("undef_code", 32'({fault, fault_code}), 32'b111);
        chk("undef_state", 32'(state_out), 32'd7);
        do_reset();
        do_instr(32'h04110003, 0, 99, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, -1, nc);
        chk("dmem_to_code", 32'({fault, fault_code}), 32'b110);
        do_reset();
        do_instr(32'hE0810312, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, -1, nc);
        do_instr(32'h04110003, 0, 3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1, nc);
        chk("mid_mem_rst_instret", 32'(instret), 32'd0);
        chk("mid_mem_rst_state", 32'(state_out), 32'd0);

        for (int n = 0; n < 300; n++) begin
            logic [31:0] w;
            int          iw, dw, rm;
            w = $urandom;
            if (w[27:26] == 2'b11 && $urandom_range(0, 3) != 0) w[27] = 1'b0;
            iw = ($urandom_range(0, 15) == 0) ? int'(TimeoutCyc + $urandom_range(0, 2))
                                               : int'($urandom_range(0, TimeoutCyc - 1));
            dw = ($urandom_range(0, 15) == 0) ? int'(TimeoutCyc + $urandom_range(0, 2))
                                               : int'($urandom_range(0, TimeoutCyc - 1));
            rm = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 1)) : -1;
            do_instr(w, iw, dw, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                     1'($urandom), rm, nc);
            if (m_faulted) do_reset();
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got no end of run, expected completion at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
Multi-cycle sequencer that wraps the combinational instruction controller and turns it into a fetch/decode/memory/retire machine. It owns the instruction register and handshakes with instruction and data memory, which may insert wait states. It qualifies the controller's decoded write enables so each architectural write fires exactly once per instruction. It also advances the PC, counts retired instructions and traps on memory timeouts and undefined opcodes.

Parameters:
TIMEOUT, 15, maximum cycles spent waiting for imem_ack or dmem_ack before faulting (>=1)
INSTRET_W, 16, width of the retired-instruction counter

Ports:
CLOCK_50  in  1  system clock, rising edge
RESET_N  in  1  asynchronous active-low reset
run  in  1  level; allows a new fetch from IDLE/RETIRE
imem_req  out  1  instruction fetch request
imem_ack  in  1  instruction word valid on imem_rdata
imem_rdata  in  32  instruction word
IR_out  out  32  latched instruction, drives the controller's IR_in
cond_pass  in  1  condition field of IR_out satisfied by current NZCV
Wen_ARd_dec  in  1  controller register-write enable (already condition-gated)
Wen_Dmem_dec  in  1  controller memory-write enable
Wen_Flags_dec  in  1  controller flag-write enable
Wen_ARd  out  1  qualified register-file write enable
Wen_Dmem  out  1  qualified data-memory write enable
Wen_Flags  out  1  qualified flag-register write enable
dmem_req  out  1  data memory access request
dmem_we  out  1  1 = store, 0 = load (valid while dmem_req)
dmem_ack  in  1  data access complete / load data valid
PC_en  out  1  PC update strobe
PC_sel_branch  out  1  with PC_en: load branch target instead of PC+4
state_out  out  3  current state encoding
fault  out  1  sticky fault flag
fault_code  out  2  01 imem timeout, 10 dmem timeout, 11 undefined op, 00 none
instret  out  INSTRET_W  retired-instruction count

Behaviour:
- Reset (RESET_N=0, asynchronous): state=IDLE, IR_out=0, wait_cnt=0, instret=0, fault=0, fault_code=00.
- All non-IR outputs are 0 at reset and are combinational from state. The Wen_* outputs additionally depend on the _dec inputs.
- Instruction class from IR_out[27:26]: 00 data-processing, 01 load/store (IR_out[20]=1 load), 10 branch, 11 undefined.
- State encoding: IDLE 000, FETCH 001, DECODE 010, MEM 011, RETIRE 100, FAULT 111.
- IDLE: all strobes 0. run=1 moves to FETCH next cycle.
- FETCH: imem_req=1.
  - imem_ack=1: IR_out<=imem_rdata, go to DECODE, wait_cnt<=0.
  - Otherwise wait_cnt++. If wait_cnt==TIMEOUT-1 with no ack, go to FAULT with code 01.
  - An ack on the last allowed cycle wins over the timeout.
- DECODE: one cycle, no strobes; the controller settles on IR_out.
  - Class 11: go to FAULT, code 11.
  - Class 01 with cond_pass=1: go to MEM, wait_cnt<=0.
  - Otherwise: go to RETIRE.
- MEM: dmem_req=1, dmem_we=~IR_out[20], Wen_Dmem=Wen_Dmem_dec & dmem_we.
  - dmem_ack=1: go to RETIRE.
  - Timeout rule as in FETCH, code 10.
- RETIRE: one cycle. PC_en=1, instret++ (wraps at 2^INSTRET_W).
  - Wen_ARd=Wen_ARd_dec for class 00, or for class 01 loads; Wen_ARd=0 otherwise.
  - Wen_Flags=Wen_Flags_dec for class 00 only.
  - PC_sel_branch=(class 10 & cond_pass).
  - Next state: run=1 goes to FETCH, run=0 goes to IDLE.
- Wen_ARd, Wen_Flags and PC_en are never asserted outside RETIRE. Wen_Dmem is never asserted outside MEM.
- FAULT: all strobes 0, fault=1, fault_code held. Only reset exits.
- Acks arriving in any state other than their waiting state are ignored.
- Dropping run mid-instruction: the instruction completes through RETIRE, then the block goes to IDLE.
- Latency with zero-wait memories: non-memory instruction 3 cycles (FETCH, DECODE, RETIRE); load/store 4 cycles.

Test Plan:
- Reset, run=1, imem returns 0xE0810312 (ADD) with immediate ack, Wen_ARd_dec=1 -> states 001,010,100; Wen_ARd=1 and PC_en=1 only in RETIRE; instret=1.
- LDR 0x04110003, cond_pass=1, dmem_ack delayed 3 cycles -> dmem_req high 4 cycles with dmem_we=0; Wen_ARd=1 in RETIRE only; total 7 cycles.
- STR 0x06010012, Wen_Dmem_dec=1 -> dmem_we=1 and Wen_Dmem=1 throughout MEM; Wen_ARd=0 in RETIRE.
- BHI 0x8A000008: cond_pass=1 -> PC_sel_branch=1 with PC_en; cond_pass=0 -> PC_sel_branch=0, PC_en=1.
- TIMEOUT=4, imem_ack never asserted -> FAULT after 4 FETCH cycles, fault_code=01. With ack on 4th cycle -> DECODE, no fault.
- Undefined word 0x0C000000 -> FAULT, code 11. Drive RESET_N low mid-MEM -> immediate IDLE, outputs 0, instret=0.
